// File: rtl/core_pkg.sv
// Shared decode types: op class enum, RV32I major opcodes, immediate formats.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package core_pkg;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_LUI,
    OP_AUIPC,
    OP_JAL,
    OP_JALR,
    OP_BRANCH,
    OP_LOAD,
    OP_STORE,
    OP_IMM,
    OP_OP,
    OP_FENCE,
    OP_SYSTEM
  } op_t;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Immediate assembly; every format sign-extends from ir[31], R-type has none.
  function automatic logic [31:0] gen_imm(input logic [31:0] ir, input imm_fmt_t fmt);
    logic [31:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{ir[31]}}, ir[31:20]};
      FMT_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      FMT_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      FMT_U:   imm = {ir[31:12], 12'd0};
      FMT_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/core_regfile.sv
// 32x32 register file: two combinational read ports, one write port, optional write bypass.
// Latency: reads are same-cycle; a write lands on the next rising clk edge.
// Backpressure: none; every requested write is performed, x0 is hardwired to zero.
module core_regfile
  import core_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  // Deliberately not reset: software initialises the architectural registers.
  logic [31:0] mem [32];

  // Write port; x0 writes are dropped so the x0 entry is never meaningful.
  always_ff @(posedge clk) begin
    if (wb_en && wb_rd != 5'd0) begin
      mem[wb_rd] <= wb_data;
    end
  end

  // Read ports: x0 reads zero first, then a same-cycle writeback wins over storage.
  always_comb begin
    rs1_val = mem[rs1];
    rs2_val = mem[rs2];
    if (BYPASS && wb_en && wb_rd == rs1) rs1_val = wb_data;
    if (BYPASS && wb_en && wb_rd == rs2) rs2_val = wb_data;
    if (rs1 == 5'd0) rs1_val = 32'd0;
    if (rs2 == 5'd0) rs2_val = 32'd0;
  end

endmodule

// File: rtl/core_decode.sv
// RV32I decode stage: classifies the instruction, builds the immediate, reads operands.
// Latency: 1 cycle from d_valid & d_ready to e_valid.
// Backpressure: holds outputs while e_ready=0; stalls fetch on load-use hazard or flush.
module core_decode
  import core_pkg::*;
#(
  parameter bit RF_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_valid,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_ir,
  output logic        d_ready,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        e_valid,
  input  logic        e_ready,
  output logic [31:0] e_pc,
  output logic [31:0] e_rs1_val,
  output logic [31:0] e_rs2_val,
  output logic [31:0] e_imm,
  output logic [4:0]  e_rd,
  output logic [4:0]  e_rs1,
  output logic [4:0]  e_rs2,
  output op_t         e_op,
  output logic [2:0]  e_funct3,
  output logic        e_alt,
  output logic        e_is_load,
  output logic        e_illegal
);

  op_t         dec_op;
  imm_fmt_t    dec_fmt;
  logic        dec_illegal;
  logic        use_rs1;
  logic        use_rs2;
  logic        writes_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [31:0] rf_rs1_val;
  logic [31:0] rf_rs2_val;
  logic        hazard;
  logic        accept;

  core_regfile #(.BYPASS(RF_BYPASS)) u_regfile (
    .clk     (clk),
    .rs1     (d_ir[19:15]),
    .rs2     (d_ir[24:20]),
    .rs1_val (rf_rs1_val),
    .rs2_val (rf_rs2_val),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data)
  );

  // Opcode classification; the format decides which register fields are real.
  always_comb begin
    dec_op      = OP_NOP;
    dec_fmt     = FMT_R;
    dec_illegal = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    writes_rd   = 1'b0;
    if (d_ir[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (d_ir[6:0])
        OPC_LUI:    begin dec_op = OP_LUI;    dec_fmt = FMT_U; writes_rd = 1'b1; end
        OPC_AUIPC:  begin dec_op = OP_AUIPC;  dec_fmt = FMT_U; writes_rd = 1'b1; end
        OPC_JAL:    begin dec_op = OP_JAL;    dec_fmt = FMT_J; writes_rd = 1'b1; end
        OPC_JALR:   begin dec_op = OP_JALR;   dec_fmt = FMT_I; writes_rd = 1'b1; use_rs1 = 1'b1; end
        OPC_BRANCH: begin dec_op = OP_BRANCH; dec_fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OPC_LOAD:   begin dec_op = OP_LOAD;   dec_fmt = FMT_I; writes_rd = 1'b1; use_rs1 = 1'b1; end
        OPC_STORE:  begin dec_op = OP_STORE;  dec_fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OPC_OP_IMM: begin dec_op = OP_IMM;    dec_fmt = FMT_I; writes_rd = 1'b1; use_rs1 = 1'b1; end
        OPC_OP:     begin dec_op = OP_OP;     dec_fmt = FMT_R; writes_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OPC_FENCE:  begin dec_op = OP_FENCE;  dec_fmt = FMT_I; writes_rd = 1'b1; use_rs1 = 1'b1; end
        OPC_SYSTEM: begin dec_op = OP_SYSTEM; dec_fmt = FMT_I; writes_rd = 1'b1; use_rs1 = 1'b1; end
        default:    dec_illegal = 1'b1;
      endcase
    end
  end

  assign dec_rs1 = use_rs1   ? d_ir[19:15] : 5'd0;
  assign dec_rs2 = use_rs2   ? d_ir[24:20] : 5'd0;
  assign dec_rd  = writes_rd ? d_ir[11:7]  : 5'd0;

  // A load still in the output register cannot feed a consumer being decoded now.
  assign hazard = e_valid && e_is_load && (e_rd != 5'd0) &&
                  ((use_rs1 && e_rd == dec_rs1) || (use_rs2 && e_rd == dec_rs2));

  assign d_ready = (~e_valid | e_ready) & ~hazard & ~flush;
  assign accept  = d_valid & d_ready;

  // Output register: reset, then flush, then load/bubble when downstream can move, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid   <= 1'b0;
      e_pc      <= 32'd0;
      e_rs1_val <= 32'd0;
      e_rs2_val <= 32'd0;
      e_imm     <= 32'd0;
      e_rd      <= 5'd0;
      e_rs1     <= 5'd0;
      e_rs2     <= 5'd0;
      e_op      <= OP_NOP;
      e_funct3  <= 3'd0;
      e_alt     <= 1'b0;
      e_is_load <= 1'b0;
      e_illegal <= 1'b0;
    end else if (flush) begin
      e_valid <= 1'b0;
    end else if (accept) begin
      e_valid   <= 1'b1;
      e_pc      <= d_pc;
      e_rs1_val <= rf_rs1_val;
      e_rs2_val <= rf_rs2_val;
      e_imm     <= gen_imm(d_ir, dec_fmt);
      e_rd      <= dec_rd;
      e_rs1     <= dec_rs1;
      e_rs2     <= dec_rs2;
      e_op      <= dec_op;
      e_funct3  <= d_ir[14:12];
      e_alt     <= d_ir[30];
      e_is_load <= (dec_op == OP_LOAD);
      e_illegal <= dec_illegal;
    end else if (~e_valid | e_ready) begin
      e_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core_decode.sv
// Randomized scoreboard bench for core_decode with a behavioural reference model.
// Latency: expects one cycle from acceptance to e_valid.
// Backpressure: drives random e_ready/flush/reset and checks stalls and holds.
module tb_core_decode;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_valid = 1'b0;
  logic [31:0] d_pc = '0;
  logic [31:0] d_ir = '0;
  logic        d_ready;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        e_valid;
  logic        e_ready = 1'b1;
  logic [31:0] e_pc, e_rs1_val, e_rs2_val, e_imm;
  logic [4:0]  e_rd, e_rs1, e_rs2;
  op_t         e_op;
  logic [2:0]  e_funct3;
  logic        e_alt, e_is_load, e_illegal;

  always #5 clk = ~clk;

  core_decode #(.RF_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_pc(d_pc), .d_ir(d_ir), .d_ready(d_ready),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .e_valid(e_valid), .e_ready(e_ready), .e_pc(e_pc), .e_rs1_val(e_rs1_val),
    .e_rs2_val(e_rs2_val), .e_imm(e_imm), .e_rd(e_rd), .e_rs1(e_rs1), .e_rs2(e_rs2),
    .e_op(e_op), .e_funct3(e_funct3), .e_alt(e_alt), .e_is_load(e_is_load),
    .e_illegal(e_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        alt;
    logic        ld;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mrf [32];
  bit          mv = 1'b0;
  bit          mload = 1'b0;
  logic [4:0]  mrd = '0;
  int          passed = 0;
  int          total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference decode straight from the ISA tables; immediates via signed arithmetic.
  task automatic ref_dec(input logic [31:0] ir, input logic [31:0] pc,
                         output exp_t e, output bit u1, output bit u2);
    int s;
    int kind; // 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, -1 illegal
    s = int'(ir);
    e = '0;
    e.op = OP_NOP;
    e.pc = pc;
    e.f3 = ir[14:12];
    e.alt = ir[30];
    kind = -1;
    case (ir[6:0])
      7'h37: begin e.op = OP_LUI;    kind = 4; end
      7'h17: begin e.op = OP_AUIPC;  kind = 4; end
      7'h6f: begin e.op = OP_JAL;    kind = 5; end
      7'h67: begin e.op = OP_JALR;   kind = 1; end
      7'h63: begin e.op = OP_BRANCH; kind = 3; end
      7'h03: begin e.op = OP_LOAD;   kind = 1; end
      7'h23: begin e.op = OP_STORE;  kind = 2; end
      7'h13: begin e.op = OP_IMM;    kind = 1; end
      7'h33: begin e.op = OP_OP;     kind = 0; end
      7'h0f: begin e.op = OP_FENCE;  kind = 1; end
      7'h73: begin e.op = OP_SYSTEM; kind = 1; end
      default: kind = -1;
    endcase
    e.ill = (kind == -1);
    e.ld  = (e.op == OP_LOAD);
    u1 = (kind >= 0 && kind <= 3);
    u2 = (e.op == OP_BRANCH || e.op == OP_STORE || e.op == OP_OP);
    e.rs1 = u1 ? ir[19:15] : 5'd0;
    e.rs2 = u2 ? ir[24:20] : 5'd0;
    e.rd  = (kind == 0 || kind == 1 || kind == 4 || kind == 5) ? ir[11:7] : 5'd0;
    case (kind)
      1: e.imm = 32'(s >>> 20);
      2: e.imm = 32'((s >>> 25) * 32 + int'(ir[11:7]));
      3: e.imm = 32'((s >>> 31) * 4096 + int'(ir[7]) * 2048 + int'(ir[30:25]) * 32 + int'(ir[11:8]) * 2);
      4: e.imm = ir & 32'hFFFFF000;
      5: e.imm = 32'((s >>> 31) * 1048576 + int'(ir[19:12]) * 4096 + int'(ir[20]) * 2048 + int'(ir[30:21]) * 2);
      default: e.imm = 32'd0;
    endcase
  endtask

  function automatic logic [31:0] rdv(input logic [4:0] a, input bit wbe,
                                      input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (wbe && wa == a) return wd;
    return mrf[a];
  endfunction

  // One clock cycle: drive, check handshake-side outputs at negedge, advance the model.
  task automatic step(input bit r, input bit dv, input logic [31:0] ir, input logic [31:0] pc,
                      input bit er, input bit fl, input bit wbe, input logic [4:0] wa,
                      input logic [31:0] wd);
    exp_t e;
    bit u1, u2, hz, rdy;
    rst = r; d_valid = dv; d_ir = ir; d_pc = pc; e_ready = er; flush = fl;
    wb_en = wbe; wb_rd = wa; wb_data = wd;
    @(negedge clk);
    ref_dec(ir, pc, e, u1, u2);
    hz  = mv && mload && mrd != 5'd0 && ((u1 && mrd == e.rs1) || (u2 && mrd == e.rs2));
    rdy = (!mv || er) && !hz && !fl;
    chk("d_ready", 64'(d_ready), 64'(rdy));
    chk("e_valid", 64'(e_valid), 64'(mv));
    e.rs1_val = rdv(ir[19:15], wbe, wa, wd);
    e.rs2_val = rdv(ir[24:20], wbe, wa, wd);
    if (r) begin
      mv = 1'b0;
      sb.delete();
    end else if (fl) begin
      mv = 1'b0;
    end else if (!mv || er) begin
      if (dv && !hz) begin
        sb.push_back(e);
        mv = 1'b1; mload = e.ld; mrd = e.rd;
      end else begin
        mv = 1'b0;
      end
    end
    if (wbe && wa != 5'd0) mrf[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit er);
    step(1'b0, 1'b0, 32'h0, 32'h0, er, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic issue(input logic [31:0] ir, input bit er);
    step(1'b0, 1'b1, ir, 32'h1000 + $urandom_range(0, 255) * 4, er, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic check_reset();
    chk("rst_e_valid", 64'(e_valid), 64'd0);
    chk("rst_e_op", 64'(e_op), 64'(OP_NOP));
    chk("rst_e_illegal", 64'(e_illegal), 64'd0);
    chk("rst_e_is_load", 64'(e_is_load), 64'd0);
    chk("rst_e_regs", 64'({e_rd, e_rs1, e_rs2}), 64'd0);
    chk("rst_e_pc", 64'(e_pc), 64'd0);
    chk("rst_e_imm", 64'(e_imm), 64'd0);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0]  opcs [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    logic [31:0] ir;
    ir = $urandom;
    if ($urandom_range(0, 15) != 0) begin
      ir[6:0]   = opcs[$urandom_range(0, 10)];
      ir[11:7]  = 5'($urandom_range(0, 7));
      ir[19:15] = 5'($urandom_range(0, 7));
      ir[24:20] = 5'($urandom_range(0, 7));
    end
    return ir;
  endfunction

  // Monitor: compares the head of the scoreboard on every completed handoff.
  logic [152:0] snap;
  bit           hold_prev = 1'b0;
  always @(negedge clk) begin
    logic [152:0] outs;
    exp_t x;
    outs = {e_pc, e_rs1_val, e_rs2_val, e_imm, e_op, e_rd, e_rs1, e_rs2, e_funct3, e_alt, e_is_load, e_illegal};
    if (hold_prev && rst === 1'b0) chk("hold_stable", 64'(outs != snap), 64'd0);
    if (rst === 1'b0 && e_valid === 1'b1 && flush === 1'b1) begin
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (rst === 1'b0 && e_valid === 1'b1 && e_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(e_valid), 64'd0);
      end else begin
        x = sb.pop_front();
        chk("e_pc", 64'(e_pc), 64'(x.pc));
        chk("e_op", 64'(e_op), 64'(x.op));
        chk("e_imm", 64'(e_imm), 64'(x.imm));
        chk("e_rs_vals", {e_rs1_val, e_rs2_val}, {x.rs1_val, x.rs2_val});
        chk("e_regs", 64'({e_rd, e_rs1, e_rs2}), 64'({x.rd, x.rs1, x.rs2}));
        chk("e_misc", 64'({e_funct3, e_alt, e_is_load, e_illegal}), 64'({x.f3, x.alt, x.ld, x.ill}));
      end
    end
    hold_prev = (rst === 1'b0 && e_valid === 1'b1 && e_ready === 1'b0 && flush === 1'b0);
    snap = outs;
  end

  initial begin
    mrf[0] = 32'd0;
    for (int i = 1; i < 32; i++) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'(i), $urandom);
    check_reset();
    idle(1'b1);
    chk("d_ready_after_rst", 64'(d_ready), 64'd1);

    // addi x1,x0,5
    issue(32'h00500093, 1'b1);
    chk("addi_valid", 64'(e_valid), 64'd1);
    chk("addi_op", 64'(e_op), 64'(OP_IMM));
    chk("addi_rd", 64'(e_rd), 64'd1);
    chk("addi_imm", 64'(e_imm), 64'd5);
    chk("addi_rs1_val", 64'(e_rs1_val), 64'd0);

    // add x4,x3,x3 with same-cycle writeback of x3
    step(1'b0, 1'b1, 32'h00318233, 32'h200, 1'b1, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF);
    chk("bypass_vals", {e_rs1_val, e_rs2_val}, 64'hDEADBEEF_DEADBEEF);

    // lw x5,0(x0) then add x6,x5,x0: one bubble, then add issues
    issue(32'h00002283, 1'b1);
    issue(32'h00028333, 1'b1);
    chk("lu_bubble", 64'(e_valid), 64'd0);
    issue(32'h00028333, 1'b1);
    chk("lu_issue", 64'({e_valid, e_rs1}), 64'({1'b1, 5'd5}));

    // three cycles of backpressure, then resume
    issue(32'h00500093, 1'b1);
    for (int i = 0; i < 3; i++) issue(32'h00318233, 1'b0);
    issue(32'h00318233, 1'b1);
    chk("resume_op", 64'({e_valid, e_op}), 64'({1'b1, OP_OP}));

    // flush under backpressure, then x0 write must not leak
    issue(32'h00500093, 1'b1);
    step(1'b0, 1'b1, 32'h00318233, 32'h300, 1'b0, 1'b1, 1'b1, 5'd0, 32'd7);
    chk("flush_valid", 64'(e_valid), 64'd0);
    step(1'b0, 1'b1, 32'h00500093, 32'h304, 1'b1, 1'b0, 1'b1, 5'd0, 32'd7);
    chk("x0_read", 64'(e_rs1_val), 64'd0);

    // reset in the middle of a stall
    issue(32'h00500093, 1'b1);
    issue(32'h00318233, 1'b0);
    step(1'b1, 1'b1, 32'h00318233, 32'h400, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    check_reset();
    idle(1'b1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, rand_ir(), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
